// File: rtl/jpeg_dequant.sv
// JPEG dequantizer: DQT table loader plus a 2-stage coefficient multiply/saturate pipe.
// Optional JPEG_DEQUANT_SATCNT_EN adds SatCount, a per-block count of saturated products.
module jpeg_dequant #(
  parameter int NUM_TABLES = 4,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                 rst,
  input  logic                 clk,
  input  logic                 DqtStart,
  input  logic                 DqtEnable,
  input  logic [7:0]           DqtData,
  output logic                 DqtBusy,
  output logic                 DqtError,
  input  logic                 CoefEnable,
  input  logic [5:0]           CoefAddress,
  input  logic [15:0]          CoefData,
  input  logic [1:0]           CoefTable,
  input  logic                 CoefLast,
  output logic                 OutEnable,
  output logic [5:0]           OutAddress,
  output logic [OUT_WIDTH-1:0] OutData,
  output logic                 BlockDone
`ifdef JPEG_DEQUANT_SATCNT_EN
  , output logic [7:0]         SatCount
`endif
);

  localparam int STAGES = 2;
  localparam int PW     = 25;
  localparam logic [4:0]          NT   = 5'(NUM_TABLES);
  localparam logic signed [PW-1:0] MAXV = PW'((2 ** (OUT_WIDTH - 1)) - 1);
  localparam logic signed [PW-1:0] MINV = -MAXV - PW'(1);

  typedef enum logic [1:0] {IDLE, LOAD, SKIP} state_t;

  state_t     state;
  logic [6:0] cnt;
  logic [6:0] last_cnt;
  logic [1:0] tq;
  logic [7:0] tbl [NUM_TABLES][64];

  assign DqtBusy = (state != IDLE);

  // A new header always wins, even mid-load; already written entries stay.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      last_cnt <= '0;
      tq       <= '0;
      DqtError <= 1'b0;
      for (int t = 0; t < NUM_TABLES; t++)
        for (int i = 0; i < 64; i++)
          tbl[t][i] <= 8'h01;
    end else if (DqtStart) begin
      cnt      <= '0;
      tq       <= DqtData[1:0];
      last_cnt <= (DqtData[7:4] == 4'd1) ? 7'd127 : 7'd63;
      if (DqtData[7:4] == 4'd0 && {1'b0, DqtData[3:0]} < NT) begin
        state <= LOAD;
      end else begin
        state    <= SKIP;
        DqtError <= 1'b1;
      end
    end else if (DqtEnable) begin
      case (state)
        LOAD: begin
          tbl[tq][cnt[5:0]] <= DqtData;
          cnt <= cnt + 7'd1;
          if (cnt == last_cnt) state <= IDLE;
        end
        SKIP: begin
          cnt <= cnt + 7'd1;
          if (cnt == last_cnt) state <= IDLE;
        end
        default: ;
      endcase
    end
  end

  logic [STAGES:1]        vld_pipe;
  logic [5:0]             s1_addr;
  logic [15:0]            s1_data;
  logic [7:0]             s1_q;
  logic                   s1_last;
  logic signed [PW-1:0]   prod;
  logic                   sat_hi, sat_lo;
  logic [OUT_WIDTH-1:0]   sat_val;

  always_comb begin
    prod    = $signed(s1_data) * $signed({1'b0, s1_q});
    sat_hi  = prod > MAXV;
    sat_lo  = prod < MINV;
    sat_val = sat_hi ? MAXV[OUT_WIDTH-1:0] :
              sat_lo ? MINV[OUT_WIDTH-1:0] : prod[OUT_WIDTH-1:0];
  end

  assign OutEnable = vld_pipe[STAGES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe   <= '0;
      s1_addr    <= '0;
      s1_data    <= '0;
      s1_q       <= '0;
      s1_last    <= 1'b0;
      OutAddress <= '0;
      OutData    <= '0;
      BlockDone  <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], CoefEnable};
      // Table read sees the pre-write entry when a load hits the same slot.
      s1_addr  <= CoefAddress;
      s1_data  <= CoefData;
      s1_q     <= tbl[CoefTable][CoefAddress];
      s1_last  <= CoefEnable & CoefLast;
      BlockDone <= vld_pipe[1] & s1_last;
      if (vld_pipe[1]) begin
        OutAddress <= s1_addr;
        OutData    <= sat_val;
      end
    end
  end

`ifdef JPEG_DEQUANT_SATCNT_EN
  // Address 0 opens a new block, so its write restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      SatCount <= '0;
    end else if (vld_pipe[1]) begin
      if (s1_addr == 6'd0)
        SatCount <= {7'd0, sat_hi | sat_lo};
      else if ((sat_hi | sat_lo) && SatCount != 8'hFF)
        SatCount <= SatCount + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_jpeg_dequant.sv
// Bench for jpeg_dequant: vector table plus hand sequences, scoreboard-checked outputs.
module tb_jpeg_dequant;
  logic        clk, rst;
  logic        DqtStart, DqtEnable;
  logic [7:0]  DqtData;
  logic        DqtBusy, DqtError;
  logic        CoefEnable, CoefLast;
  logic [5:0]  CoefAddress;
  logic [15:0] CoefData;
  logic [1:0]  CoefTable;
  logic        OutEnable, BlockDone;
  logic [5:0]  OutAddress;
  logic [15:0] OutData;
`ifdef JPEG_DEQUANT_SATCNT_EN
  logic [7:0]  SatCount;
`endif

  jpeg_dequant dut (
    .rst(rst), .clk(clk),
    .DqtStart(DqtStart), .DqtEnable(DqtEnable), .DqtData(DqtData),
    .DqtBusy(DqtBusy), .DqtError(DqtError),
    .CoefEnable(CoefEnable), .CoefAddress(CoefAddress), .CoefData(CoefData),
    .CoefTable(CoefTable), .CoefLast(CoefLast),
    .OutEnable(OutEnable), .OutAddress(OutAddress), .OutData(OutData),
    .BlockDone(BlockDone)
`ifdef JPEG_DEQUANT_SATCNT_EN
    , .SatCount(SatCount)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct { logic [5:0] a; logic [15:0] d; logic [1:0] t; logic [15:0] e; } vec_t;
  typedef struct { logic [5:0] a; logic [15:0] d; logic l; } exp_t;

  exp_t sb[$];
  int   total = 0, bad = 0;
  int   oe_cnt = 0, bd_cnt = 0, max_run = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic monitor();
    int   run;
    exp_t e;
    run = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (OutEnable) begin
          oe_cnt++;
          run++;
          if (run > max_run) max_run = run;
          if (sb.size() == 0) chk("unexpected_oe", 1, 0);
          else begin
            e = sb.pop_front();
            chk("out_addr", OutAddress, e.a);
            chk("out_data", $signed(OutData), $signed(e.d));
            chk("block_done", BlockDone, e.l);
          end
        end else begin
          run = 0;
          if (BlockDone) chk("bd_without_oe", 1, 0);
        end
        if (BlockDone) bd_cnt++;
      end
    end
  endtask

  task automatic coef(input logic [5:0] a, input logic [15:0] d, input logic [1:0] t,
                      input logic l, input logic [15:0] e, input logic push);
    CoefEnable = 1'b1; CoefAddress = a; CoefData = d; CoefTable = t; CoefLast = l;
    if (push) sb.push_back('{a, e, l});
    @(posedge clk); #1;
    CoefEnable = 1'b0; CoefLast = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    chk("drain", sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic dqt_start(input logic [7:0] hdr);
    DqtStart = 1'b1; DqtData = hdr;
    @(posedge clk); #1;
    DqtStart = 1'b0;
  endtask

  task automatic dqt_load(input logic [7:0] hdr, input int n, input int kind, output int bc);
    dqt_start(hdr);
    bc = 0;
    for (int k = 0; k < n; k++) begin
      if (DqtBusy) bc++;
      DqtEnable = 1'b1;
      case (kind)
        0:       DqtData = (k == 0) ? 8'd255 : 8'(k);
        1:       DqtData = 8'(2 * (k + 1));
        2:       DqtData = 8'd0;
        3:       DqtData = 8'd4;
        default: DqtData = 8'h77;
      endcase
      @(posedge clk); #1;
    end
    DqtEnable = 1'b0;
  endtask

  vec_t vt[14];
  int   bc;

  initial begin
    fork monitor(); join_none
    // table0: entry0=255, entry k=k; table1: 2*(k+1); table2 unloaded; table3 zeros
    vt[0]  = '{6'd5,  16'd3,          2'd2, 16'd3};
    vt[1]  = '{6'd10, 16'(-7),        2'd1, 16'(-154)};
    vt[2]  = '{6'd0,  16'd300,        2'd0, 16'd32767};
    vt[3]  = '{6'd0,  16'(-300),      2'd0, 16'h8000};
    vt[4]  = '{6'd1,  16'd100,        2'd0, 16'd100};
    vt[5]  = '{6'd40, 16'd800,        2'd0, 16'd32000};
    vt[6]  = '{6'd40, 16'd820,        2'd0, 16'd32767};
    vt[7]  = '{6'd63, 16'(-520),      2'd0, 16'(-32760)};
    vt[8]  = '{6'd7,  16'd1234,       2'd3, 16'd0};
    vt[9]  = '{6'd63, 16'd32767,      2'd1, 16'd32767};
    vt[10] = '{6'd0,  16'h8000,       2'd1, 16'h8000};
    vt[11] = '{6'd2,  16'hFFFF,       2'd2, 16'hFFFF};
    vt[12] = '{6'd0,  16'd128,        2'd0, 16'd32640};
    vt[13] = '{6'd0,  16'h8000,       2'd2, 16'h8000};

    rst = 1'b0; DqtStart = 0; DqtEnable = 0; DqtData = 0;
    CoefEnable = 0; CoefLast = 0; CoefAddress = 0; CoefData = 0; CoefTable = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_oe", OutEnable, 0);
    chk("rst_addr", OutAddress, 0);
    chk("rst_data", OutData, 0);
    chk("rst_bd", BlockDone, 0);
    chk("rst_busy", DqtBusy, 0);
    chk("rst_err", DqtError, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    coef(6'd5, 16'd3, 2'd2, 1'b0, 16'd3, 1'b1);
    drain();

    dqt_load(8'h01, 64, 1, bc);
    chk("load1_busy_cycles", bc, 64);
    chk("load1_busy_after", DqtBusy, 0);
    dqt_load(8'h00, 64, 0, bc);
    dqt_load(8'h03, 64, 2, bc);
    chk("no_err_yet", DqtError, 0);

    foreach (vt[i]) coef(vt[i].a, vt[i].d, vt[i].t, 1'b0, vt[i].e, 1'b1);
    drain();

    // stray CoefLast must not produce BlockDone
    bd_cnt = 0;
    CoefLast = 1'b1;
    repeat (3) @(posedge clk);
    #1; CoefLast = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("last_no_enable", bd_cnt, 0);

`ifdef JPEG_DEQUANT_SATCNT_EN
    coef(6'd0, 16'd300, 2'd0, 1'b0, 16'd32767, 1'b1);
    coef(6'd40, 16'd1000, 2'd0, 1'b0, 16'd32767, 1'b1);
    coef(6'd1, 16'd5, 2'd0, 1'b0, 16'd5, 1'b1);
    drain();
    chk("satcount_two", SatCount, 2);
    coef(6'd0, 16'd1, 2'd0, 1'b0, 16'd255, 1'b1);
    drain();
    chk("satcount_clear", SatCount, 0);
`endif

    oe_cnt = 0; bd_cnt = 0; max_run = 0;
    for (int a = 0; a < 64; a++)
      coef(6'(a), 16'(a * 3 - 50), 2'd2, a == 63, 16'(a * 3 - 50), 1'b1);
    drain();
    chk("b2b_oe_count", oe_cnt, 64);
    chk("b2b_oe_run", max_run, 64);
    chk("b2b_bd_count", bd_cnt, 1);

    // same-cycle write and read of table2 entry 0, then restart into table3
    dqt_start(8'h02);
    DqtEnable = 1'b1; DqtData = 8'd5;
    coef(6'd0, 16'd10, 2'd2, 1'b0, 16'd10, 1'b1);
    DqtData = 8'd1;
    coef(6'd0, 16'd10, 2'd2, 1'b0, 16'd50, 1'b1);
    DqtData = 8'd1;
    @(posedge clk); #1;
    DqtEnable = 1'b0;
    dqt_load(8'h03, 64, 3, bc);
    chk("restart_busy_cycles", bc, 64);
    chk("restart_busy_after", DqtBusy, 0);
    coef(6'd9, 16'd10, 2'd3, 1'b0, 16'd40, 1'b1);
    coef(6'd0, 16'd10, 2'd2, 1'b0, 16'd50, 1'b1);
    coef(6'd1, 16'd10, 2'd2, 1'b0, 16'd10, 1'b1);
    drain();

    dqt_load(8'h10, 128, 4, bc);
    chk("pq1_err", DqtError, 1);
    chk("pq1_skip_cycles", bc, 128);
    chk("pq1_busy_after", DqtBusy, 0);
    coef(6'd0, 16'd1, 2'd0, 1'b0, 16'd255, 1'b1);
    coef(6'd5, 16'd2, 2'd0, 1'b0, 16'd10, 1'b1);
    drain();

    // reset with a coefficient in flight
    oe_cnt = 0;
    coef(6'd4, 16'd9, 2'd2, 1'b0, 16'd0, 1'b0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("inflight_rst_oe", OutEnable, 0);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("inflight_no_oe", oe_cnt, 0);

    // reset mid-load
    dqt_start(8'h02);
    for (int k = 0; k < 20; k++) begin
      DqtEnable = 1'b1; DqtData = 8'd9;
      @(posedge clk); #1;
    end
    DqtEnable = 1'b0;
    rst = 1'b0;
    #2;
    chk("midload_busy", DqtBusy, 0);
    chk("midload_err", DqtError, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    for (int t = 0; t < 4; t++)
      for (int a = 0; a < 64; a++)
        coef(6'(a), 16'd100, 2'(t), 1'b0, 16'd100, 1'b1);
    drain();

    dqt_load(8'h05, 64, 4, bc);
    chk("tq5_err", DqtError, 1);
    chk("tq5_skip_cycles", bc, 64);
    chk("tq5_busy_after", DqtBusy, 0);

    // DqtEnable in IDLE does nothing
    for (int k = 0; k < 5; k++) begin
      DqtEnable = 1'b1; DqtData = 8'd33;
      @(posedge clk); #1;
    end
    DqtEnable = 1'b0;
    chk("idle_enable_busy", DqtBusy, 0);
    coef(6'd3, 16'd7, 2'd0, 1'b0, 16'd7, 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
